// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq
//  Description : Sequential RISC-V ALU with valid/ready handshakes, 1 bit/cycle
//                shifter and iterative shift-add multiplier; registered result.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_seq #(
    parameter int WIDTH  = 32,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] c_op_add  = 4'b0000;
    localparam logic [3:0] c_op_sub  = 4'b0001;
    localparam logic [3:0] c_op_and  = 4'b0010;
    localparam logic [3:0] c_op_or   = 4'b0011;
    localparam logic [3:0] c_op_xor  = 4'b0100;
    localparam logic [3:0] c_op_slt  = 4'b0101;
    localparam logic [3:0] c_op_sltu = 4'b0110;
    localparam logic [3:0] c_op_sll  = 4'b0111;
    localparam logic [3:0] c_op_srl  = 4'b1000;
    localparam logic [3:0] c_op_sra  = 4'b1001;
    localparam logic [3:0] c_op_mul  = 4'b1010;

    localparam logic           c_mul_en     = (MUL_EN != 0);
    localparam logic [SHW:0]   c_mul_cycles = (SHW+1)'(WIDTH);
    localparam logic [SHW:0]   c_cnt_one    = (SHW+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_MUL   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [SHW:0]     r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;

    logic             w_accept;
    logic             w_is_shift;
    logic             w_is_mul;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_alu;
    logic [WIDTH-1:0] w_shift_next;
    logic [WIDTH-1:0] w_mul_next;

    assign in_ready   = (r_state == S_IDLE);
    assign out_valid  = (r_state == S_DONE);
    assign busy       = (r_state == S_SHIFT) || (r_state == S_MUL);
    assign alu_result = r_result;
    assign zero       = r_zero;

    assign w_accept   = in_valid && in_ready;
    assign w_shamt    = src_b[SHW-1:0];
    assign w_is_shift = (alu_control == c_op_sll) || (alu_control == c_op_srl) ||
                        (alu_control == c_op_sra);
    assign w_is_mul   = c_mul_en && (alu_control == c_op_mul);

    // Single-cycle ops; anything not listed (incl. MUL here) yields zero.
    always_comb begin
        w_alu = '0;
        case (alu_control)
            c_op_add:  w_alu = src_a + src_b;
            c_op_sub:  w_alu = src_a - src_b;
            c_op_and:  w_alu = src_a & src_b;
            c_op_or:   w_alu = src_a | src_b;
            c_op_xor:  w_alu = src_a ^ src_b;
            c_op_slt:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            c_op_sltu: w_alu = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
            default:   w_alu = '0;
        endcase
    end

    always_comb begin
        w_shift_next = r_acc << 1;
        if (r_op == c_op_srl) begin
            w_shift_next = r_acc >> 1;
        end else if (r_op == c_op_sra) begin
            w_shift_next = {r_acc[WIDTH-1], r_acc[WIDTH-1:1]};
        end
    end

    assign w_mul_next = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_is_shift && (w_shamt != '0)) begin
                        w_next_state = S_SHIFT;
                    end else if (w_is_mul) begin
                        w_next_state = S_MUL;
                    end else begin
                        w_next_state = S_DONE;
                    end
                end
            end
            S_SHIFT, S_MUL: begin
                if (r_cnt == c_cnt_one) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op <= alu_control;
                        if (w_is_shift) begin
                            r_acc <= src_a;
                            r_cnt <= {1'b0, w_shamt};
                            // Zero shift amount completes immediately with src_a.
                            if (w_shamt == '0) begin
                                r_result <= src_a;
                                r_zero   <= (src_a == '0);
                            end
                        end else if (w_is_mul) begin
                            r_acc    <= '0;
                            r_mcand  <= src_a;
                            r_mplier <= src_b;
                            r_cnt    <= c_mul_cycles;
                        end else begin
                            r_result <= w_alu;
                            r_zero   <= (w_alu == '0);
                        end
                    end
                end
                S_SHIFT: begin
                    r_acc <= w_shift_next;
                    r_cnt <= r_cnt - c_cnt_one;
                    if (r_cnt == c_cnt_one) begin
                        r_result <= w_shift_next;
                        r_zero   <= (w_shift_next == '0);
                    end
                end
                S_MUL: begin
                    r_acc    <= w_mul_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt - c_cnt_one;
                    if (r_cnt == c_cnt_one) begin
                        r_result <= w_mul_next;
                        r_zero   <= (w_mul_next == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
